imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Front-panel writer for the processor's 128 x 16 instruction memory; the processor side is the reader of that memory.
- The user sets a 16-bit word on SW[15:0] and presses the filtered Enter key. The block writes the word at the next address, reads it back, and checks it.
- It holds the processor in load mode (LoadActive) until loading finishes. It sits between the key-filter outputs and the instruction memory's write/read ports.

Parameters:
- AW, 7, address width; 7 matches the PC width.
- DW, 16, instruction word width.
- WORDS, 128, memory depth; last valid address is WORDS-1.

Ports:
- Clk  input  1  system clock (50 MHz); all state changes on the rising edge.
- ResetN  input  1  asynchronous active-low reset.
- Enter  input  1  one-cycle pulse from the key filter: accept DataIn.
- Finish  input  1  one-cycle pulse from the key filter: end loading early.
- DataIn  input  DW  word to load (SW[15:0]).
- RdData  input  DW  memory read data, registered; valid one cycle after RdAddr.
- WrEn  output  1  memory write strobe.
- WrAddr  output  AW  memory write address.
- WrData  output  DW  memory write data.
- RdAddr  output  AW  memory read address.
- Count  output  AW+1  number of words verified so far (0..WORDS).
- LoadActive  output  1  high while loading; the processor is held idle.
- Done  output  1  loading completed successfully.
- Error  output  1  readback mismatch detected.

Behaviour:
- Reset (asynchronous, ResetN=0):
  - State=IDLE; address register=0; Count=0; data latch=0.
  - WrEn=0, WrAddr=0, WrData=0, RdAddr=0.
  - LoadActive=1, Done=0, Error=0.
  - Reset asserted mid-operation aborts any write/check immediately. Memory contents already written are not cleared.
- Moore FSM. Outputs decode from the state register, the address register and the data latch. WrAddr=RdAddr=address register at all times. WrData=data latch.
- IDLE:
  - Enter=1: latch DataIn, go to WRITE.
  - Else Finish=1 and Count>0: go to DONE.
  - Finish with Count=0 is ignored. Enter and Finish in the same cycle: Enter wins, Finish is dropped.
- WRITE: WrEn=1 for exactly this one cycle; next state READ.
- READ: RdAddr is presented (memory samples it at this edge); next state CHECK.
- CHECK: compare RdData with the data latch.
  - Match: Count increments. If address=WORDS-1, next state DONE with the address held (no wrap). Otherwise the address increments and next state is IDLE.
  - Mismatch: next state ERR; address and Count are unchanged.
- DONE: LoadActive=0, Done=1. Sticky until reset; Enter and Finish are ignored.
- ERR: Error=1, LoadActive=1. Sticky until reset; Enter and Finish are ignored. WrAddr shows the failing address.
- Timing: Enter sampled at edge 0 gives WrEn high from edge 0 to edge 1, READ after edge 1, CHECK after edge 2, and IDLE/DONE/ERR after edge 3.
  - Count updates at edge 3.
  - Minimum spacing between accepted Enter pulses is 4 cycles.
- Enter pulses arriving in WRITE, READ or CHECK are discarded, not queued.
- Count never exceeds WORDS; the address register never wraps past WORDS-1.
- WrEn is never asserted outside WRITE; at most one write occurs per accepted Enter.

Test Plan:
- Reset check: hold ResetN=0 with Enter and Finish toggling -> WrEn=0, Count=0, LoadActive=1, Done=0, Error=0 throughout.
- Single load: DataIn=16'h1A2B, Enter pulse; bench memory model echoes the write -> WrEn high one cycle at WrAddr=0 with WrData=16'h1A2B; RdAddr=0; Count becomes 1 at edge 3; state returns to IDLE with address=1.
- Early finish: load 3 words (16'h0001, 16'h0002, 16'h0003), then a Finish pulse -> Done=1, LoadActive=0, Count=3. A further Enter causes no WrEn.
- Finish with no words: Finish pulse right after reset -> no state change, LoadActive=1, Done=0.
- Full memory: 128 Enter pulses with DataIn=address -> the 128th check sets Done=1 and Count=128, WrAddr holds 7'd127 (no wrap), and exactly 128 WrEn pulses are seen.
- Fault and ignore cases:
  - Memory model corrupts address 5 (returns 16'hFFFF for 16'h0005) -> Error=1 after edge 3 of that load; Count=5, WrAddr=5; later Enter pulses are ignored.
  - Separately, an Enter in the cycle after an accepted Enter, and Enter+Finish together in IDLE -> one write only, and no transition to DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Front-panel loader for the 128 x 16 instruction memory: writes each entered
// word at the next address, reads it back and checks it before advancing.
module imem_loader #(
    parameter int AW    = 7,
    parameter int DW    = 16,
    parameter int WORDS = 128
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          Enter,
    input  logic          Finish,
    input  logic [DW-1:0] DataIn,
    input  logic [DW-1:0] RdData,
    output logic          WrEn,
    output logic [AW-1:0] WrAddr,
    output logic [DW-1:0] WrData,
    output logic [AW-1:0] RdAddr,
    output logic [AW:0]   Count,
    output logic          LoadActive,
    output logic          Done,
    output logic          Error
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t        state, next_state;
    logic [AW-1:0] addr;
    logic [AW:0]   count;
    logic [DW-1:0] data_latch;
    logic          match;
    logic          last;

    assign match = (RdData == data_latch);
    assign last  = (addr == AW'(WORDS - 1));

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The final address is held rather than wrapped so WrAddr keeps pointing at it.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            addr       <= '0;
            count      <= '0;
            data_latch <= '0;
        end else begin
            if (state == IDLE && Enter) begin
                data_latch <= DataIn;
            end
            if (state == CHECK && match) begin
                count <= count + 1'b1;
                if (!last) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Enter) begin
                    next_state = WRITE;
                end else if (Finish && count != '0) begin
                    next_state = DONE;
                end
            end
            WRITE: next_state = READ;
            READ:  next_state = CHECK;
            CHECK: begin
                if (!match) begin
                    next_state = ERR;
                end else if (last) begin
                    next_state = DONE;
                end else begin
                    next_state = IDLE;
                end
            end
            DONE:    next_state = DONE;
            ERR:     next_state = ERR;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        WrEn       = (state == WRITE);
        WrAddr     = addr;
        RdAddr     = addr;
        WrData     = data_latch;
        Count      = count;
        LoadActive = (state != DONE);
        Done       = (state == DONE);
        Error      = (state == ERR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven vectors, directed corner sequences and
// random Enter/Finish traffic checked against a transaction-level model.
module tb_imem_loader;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int WORDS = 128;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b0;
    logic          Enter = 1'b0;
    logic          Finish = 1'b0;
    logic [DW-1:0] DataIn = '0;
    logic [DW-1:0] RdData = '0;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic [AW-1:0] RdAddr;
    logic [AW:0]   Count;
    logic          LoadActive;
    logic          Done;
    logic          Error;

    imem_loader #(.AW(AW), .DW(DW), .WORDS(WORDS)) dut (
        .Clk(Clk), .ResetN(ResetN), .Enter(Enter), .Finish(Finish),
        .DataIn(DataIn), .RdData(RdData), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .RdAddr(RdAddr), .Count(Count),
        .LoadActive(LoadActive), .Done(Done), .Error(Error)
    );

    always #10 Clk = ~Clk;

    // Memory model: registered read, optional corruption of address 5.
    logic [DW-1:0] mem [WORDS];
    logic          corrupt5 = 1'b0;
    always @(posedge Clk) begin
        if (WrEn) mem[WrAddr] <= (corrupt5 && WrAddr == 7'd5) ? 16'hFFFF : WrData;
        RdData <= mem[RdAddr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int wr_pulses = 0;

    // Transaction-level reference: phase counts cycles since an accepted Enter.
    int          m_phase;
    int          m_count;
    bit          m_done;
    bit          m_err;
    logic [DW-1:0] m_data;

    function automatic int m_addr();
        return (m_count < WORDS) ? m_count : WORDS - 1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_done = 0; m_err = 0; m_data = '0;
    endtask

    task automatic model_edge(input bit en, input bit fin, input logic [DW-1:0] d);
        if (m_done || m_err) return;
        case (m_phase)
            0: begin
                if (en) begin
                    m_phase = 1;
                    m_data  = d;
                end else if (fin && m_count > 0) begin
                    m_done = 1;
                end
            end
            1: m_phase = 2;
            2: m_phase = 3;
            default: begin
                m_phase = 0;
                if (corrupt5 && m_addr() == 5 && m_data != 16'hFFFF) begin
                    m_err = 1;
                end else begin
                    m_count++;
                    if (m_count == WORDS) m_done = 1;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("m_wren",  32'(WrEn),       32'(m_phase == 1 && !m_done && !m_err));
        check("m_waddr", 32'(WrAddr),     32'(m_addr()));
        check("m_raddr", 32'(RdAddr),     32'(m_addr()));
        check("m_count", 32'(Count),      32'(m_count));
        check("m_load",  32'(LoadActive), 32'(!m_done));
        check("m_done",  32'(Done),       32'(m_done));
        check("m_err",   32'(Error),      32'(m_err));
        if (m_phase == 1 && !m_done && !m_err) check("m_wdata", 32'(WrData), 32'(m_data));
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge.
    task automatic step(input bit en, input bit fin, input logic [DW-1:0] d);
        Enter = en; Finish = fin; DataIn = d;
        model_edge(en, fin, d);
        @(posedge Clk);
        #1;
        Enter = 1'b0; Finish = 1'b0;
        if (WrEn) wr_pulses++;
        check_model();
    endtask

    task automatic load_word(input logic [DW-1:0] d);
        step(1'b1, 1'b0, d);
        repeat (3) step(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            Enter = i[0]; Finish = ~i[0]; DataIn = 16'hBEEF;
            @(posedge Clk);
            #1;
            check("rst_wren",  32'(WrEn), 32'd0);
            check("rst_count", 32'(Count), 32'd0);
            check("rst_load",  32'(LoadActive), 32'd1);
            check("rst_done",  32'(Done), 32'd0);
            check("rst_err",   32'(Error), 32'd0);
            check("rst_wdata", 32'(WrData), 32'd0);
        end
        Enter = 1'b0; Finish = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        wr_pulses = 0;
    endtask

    typedef struct {
        bit            en;
        bit            fin;
        logic [DW-1:0] d;
        bit            wren;
        logic [AW-1:0] addr;
        logic [AW:0]   cnt;
        bit            load;
        bit            done;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Finish with nothing loaded, single load of 1A2B with a discarded Enter,
        // Enter+Finish together, Finish during CHECK, then a real Finish.
        vecs[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 7'd0, 8'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h1A2B, 1'b1, 7'd0, 8'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'd0, 8'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h5555, 1'b0, 7'd0, 8'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'd1, 8'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 7'd1, 8'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'd1, 8'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'd1, 8'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 7'd2, 8'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 7'd2, 8'd2, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 16'h7777, 1'b0, 7'd2, 8'd2, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].en, vecs[i].fin, vecs[i].d);
            check($sformatf("vec%0d_wren", i),  32'(WrEn),       32'(vecs[i].wren));
            check($sformatf("vec%0d_addr", i),  32'(WrAddr),     32'(vecs[i].addr));
            check($sformatf("vec%0d_count", i), 32'(Count),      32'(vecs[i].cnt));
            check($sformatf("vec%0d_load", i),  32'(LoadActive), 32'(vecs[i].load));
            check($sformatf("vec%0d_done", i),  32'(Done),       32'(vecs[i].done));
            if (vecs[i].wren) check($sformatf("vec%0d_wdata", i), 32'(WrData), 32'(vecs[i].d));
        end
        check("vec_wr_pulses", 32'(wr_pulses), 32'd2);

        // Early finish after three words.
        do_reset();
        load_word(16'h0001); load_word(16'h0002); load_word(16'h0003);
        step(1'b0, 1'b1, '0);
        check("early_done",  32'(Done), 32'd1);
        check("early_count", 32'(Count), 32'd3);
        step(1'b1, 1'b0, 16'h0004);
        step(1'b0, 1'b0, '0);
        check("early_pulses", 32'(wr_pulses), 32'd3);

        // Reset asserted mid-write aborts immediately.
        do_reset();
        step(1'b1, 1'b0, 16'hABCD);
        ResetN = 1'b0;
        #1;
        check("midrst_wren", 32'(WrEn), 32'd0);
        check("midrst_load", 32'(LoadActive), 32'd1);
        check("midrst_wdata", 32'(WrData), 32'd0);

        // Full memory: 128 loads, no wrap, exactly 128 writes.
        do_reset();
        for (int i = 0; i < WORDS; i++) load_word(16'(i));
        check("full_done",   32'(Done), 32'd1);
        check("full_count",  32'(Count), 32'd128);
        check("full_waddr",  32'(WrAddr), 32'd127);
        step(1'b1, 1'b0, 16'h1234);
        step(1'b0, 1'b0, '0);
        check("full_pulses", 32'(wr_pulses), 32'd128);

        // Readback fault at address 5.
        do_reset();
        corrupt5 = 1'b1;
        for (int i = 0; i < 6; i++) load_word(16'(i));
        check("fault_err",   32'(Error), 32'd1);
        check("fault_count", 32'(Count), 32'd5);
        check("fault_waddr", 32'(WrAddr), 32'd5);
        step(1'b1, 1'b0, 16'h0006);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        check("fault_pulses", 32'(wr_pulses), 32'd6);
        check("fault_done",   32'(Done), 32'd0);
        corrupt5 = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0),
                 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
